sram_controller: RTL and testbench

Multi-cycle controller that sits between the MEM stage and an external 16-bit asynchronous SRAM, replacing the single-cycle on-chip data memory. It turns a 32-bit word read or write into two sequenced half-word SRAM accesses. It drives `ready` low to freeze the pipeline until the access completes. Word addresses are byte addresses offset by `BASE_ADDR` and divided by 4; the high bits are truncated.

---
 rtl/sram_controller.sv | 143 ++++++++++++++
 tb/tb_sram_controller.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// sram_controller: turns a 32-bit word access into two sequenced
// half-word accesses on a 16-bit asynchronous SRAM, stalling the pipeline.
module sram_controller #(
    parameter int          WAIT_CYCLES = 2,
    parameter int          SRAM_ADDR_W = 18,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_r_en,
    input  logic                   mem_w_en,
    input  logic [31:0]            address,
    input  logic [31:0]            dataToWrite,
    output logic [31:0]            result,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [15:0]            sram_dq_out,
    input  logic [15:0]            sram_dq_in,
    output logic                   sram_dq_oe,
    output logic                   sram_we_n,
    output logic                   sram_oe_n
);

    localparam int IDX_W = SRAM_ADDR_W - 1;
    localparam int CNT_W = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   is_wr_q, is_wr_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [31:0]            result_q, result_d;
    logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]            dq_q, dq_d;

    logic req;
    logic last;
    logic active;

    assign req    = mem_r_en | mem_w_en;
    assign last   = (cnt_q == '0);
    assign active = (state_q == S_LO) || (state_q == S_HI);

    // Handshake and SRAM strobes decoded from the current state
    assign ready       = (state_q == S_DONE) || ((state_q == S_IDLE) && !req);
    assign sram_we_n   = !(active && is_wr_q && !last);
    assign sram_oe_n   = !(active && !is_wr_q);
    assign sram_dq_oe  = active && is_wr_q;
    assign sram_addr   = addr_q;
    assign sram_dq_out = dq_q;
    assign result      = result_q;

    // Next-state, counter, request latching, address/data and read capture
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_wr_d  = is_wr_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        result_d = result_q;
        addr_d   = addr_q;
        dq_d     = dq_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    // Write takes priority when both enables are high
                    is_wr_d = mem_w_en;
                    idx_d   = IDX_W'((address - BASE_ADDR) >> 2);
                    wdata_d = dataToWrite;
                    cnt_d   = CNT_LOAD;
                    addr_d  = {idx_d, 1'b0};
                    if (mem_w_en) begin
                        dq_d = dataToWrite[15:0];
                    end
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (last) begin
                    if (!is_wr_q) begin
                        result_d[15:0] = sram_dq_in;
                    end
                    cnt_d  = CNT_LOAD;
                    addr_d = {idx_q, 1'b1};
                    if (is_wr_q) begin
                        dq_d = wdata_q[31:16];
                    end
                    state_d = S_HI;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_HI: begin
                if (last) begin
                    if (!is_wr_q) begin
                        result_d[31:16] = sram_dq_in;
                    end
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_wr_q  <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
            result_q <= '0;
            addr_q   <= '0;
            dq_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_wr_q  <= is_wr_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            result_q <= result_d;
            addr_q   <= addr_d;
            dq_q     <= dq_d;
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: directed checks of the SRAM controller with a
// behavioural SRAM, plus a second instance for the longer wait setting.
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_r_en, mem_w_en;
    logic [31:0] address, dataToWrite;
    logic [31:0] result;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_we_n, sram_oe_n;

    logic        r3;
    logic [31:0] result3;
    logic        ready3;
    logic [17:0] sram_addr3;
    logic [15:0] sram_dq_out3;
    logic        sram_dq_oe3, sram_we_n3, sram_oe_n3;

    logic [15:0] mem [0:262143];

    int errors = 0;
    int checks = 0;

    logic [17:0] addr_s [0:19];
    logic [15:0] dq_s   [0:19];
    logic [31:0] res_s  [0:19];
    logic [5:0]  we_v, oe_v, dqoe_v;
    int          nlow;
    logic        done_seen;
    logic [31:0] res_done;
    int          n3;
    logic        seen3;

    always #5 clk = ~clk;

    sram_controller dut (
        .clk        (clk),
        .rst        (rst),
        .mem_r_en   (mem_r_en),
        .mem_w_en   (mem_w_en),
        .address    (address),
        .dataToWrite(dataToWrite),
        .result     (result),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_in (sram_dq_in),
        .sram_dq_oe (sram_dq_oe),
        .sram_we_n  (sram_we_n),
        .sram_oe_n  (sram_oe_n)
    );

    sram_controller #(.WAIT_CYCLES(3)) dut3 (
        .clk        (clk),
        .rst        (rst),
        .mem_r_en   (r3),
        .mem_w_en   (1'b0),
        .address    (32'd1024),
        .dataToWrite(32'd0),
        .result     (result3),
        .ready      (ready3),
        .sram_addr  (sram_addr3),
        .sram_dq_out(sram_dq_out3),
        .sram_dq_in (16'h0000),
        .sram_dq_oe (sram_dq_oe3),
        .sram_we_n  (sram_we_n3),
        .sram_oe_n  (sram_oe_n3)
    );

    // Behavioural SRAM: write while strobe is low, combinational read
    always @(posedge clk) begin
        if (!sram_we_n) mem[sram_addr] <= sram_dq_out;
    end
    assign sram_dq_in = mem[sram_addr];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One access; sample i=0 is the IDLE cycle with the request
    task automatic run(input logic w, input logic r, input logic [31:0] a,
                       input logic [31:0] d, input logic hold);
        @(negedge clk);
        mem_w_en    = w;
        mem_r_en    = r;
        address     = a;
        dataToWrite = d;
        nlow        = 0;
        done_seen   = 1'b0;
        we_v        = '1;
        oe_v        = '1;
        dqoe_v      = '0;
        for (int i = 0; i < 20 && !done_seen; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            addr_s[i] = sram_addr;
            dq_s[i]   = sram_dq_out;
            res_s[i]  = result;
            if (i < 6) begin
                we_v[i]   = sram_we_n;
                oe_v[i]   = sram_oe_n;
                dqoe_v[i] = sram_dq_oe;
            end
            if (ready) begin
                done_seen = 1'b1;
                res_done  = result;
            end else begin
                nlow++;
            end
        end
        if (!hold) begin
            mem_w_en = 1'b0;
            mem_r_en = 1'b0;
        end
    endtask

    initial begin
        rst         = 1'b1;
        mem_r_en    = 1'b0;
        mem_w_en    = 1'b0;
        address     = 32'd0;
        dataToWrite = 32'd0;
        r3          = 1'b0;

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_ready", ready, 1);
        chk("rst_result", result, 0);
        chk("rst_addr", sram_addr, 0);
        chk("rst_dq", sram_dq_out, 0);
        chk("rst_we", sram_we_n, 1);
        chk("rst_oe", sram_oe_n, 1);
        chk("rst_dqoe", sram_dq_oe, 0);
        rst = 1'b0;

        // Write 0xDEADBEEF at base
        run(1, 0, 32'd1024, 32'hDEADBEEF, 0);
        chk("wr_done", done_seen, 1);
        chk("wr_low", nlow, 5);
        chk("wr_addr_lo", addr_s[1], 0);
        chk("wr_addr_hi", addr_s[3], 1);
        chk("wr_dq_lo", dq_s[1], 32'hBEEF);
        chk("wr_dq_hi", dq_s[3], 32'hDEAD);
        chk("wr_we_shape", we_v, 6'b110101);
        chk("wr_oe_shape", oe_v, 6'b111111);
        chk("wr_dqoe_shape", dqoe_v, 6'b011110);
        chk("wr_result", res_done, 0);
        chk("wr_mem0", mem[0], 32'hBEEF);
        chk("wr_mem1", mem[1], 32'hDEAD);

        // Read it back
        run(0, 1, 32'd1024, 32'h0, 0);
        chk("rd_low", nlow, 5);
        chk("rd_we_shape", we_v, 6'b111111);
        chk("rd_oe_shape", oe_v, 6'b100001);
        chk("rd_dqoe_shape", dqoe_v, 6'b000000);
        chk("rd_early_lo", res_s[3], 32'h0000BEEF);
        chk("rd_result", res_done, 32'hDEADBEEF);

        // Both enables: write wins
        run(1, 1, 32'd1028, 32'h12345678, 0);
        chk("both_low", nlow, 5);
        chk("both_addr_lo", addr_s[1], 2);
        chk("both_addr_hi", addr_s[3], 3);
        chk("both_we_shape", we_v, 6'b110101);
        chk("both_result", res_done, 32'hDEADBEEF);
        chk("both_mem2", mem[2], 32'h5678);
        chk("both_mem3", mem[3], 32'h1234);

        // Held request re-issues as a new access right after DONE
        run(0, 1, 32'd1028, 32'h0, 1);
        chk("b2b1_result", res_done, 32'h12345678);
        run(0, 1, 32'd1028, 32'h0, 0);
        chk("b2b2_low", nlow, 5);
        chk("b2b2_result", res_done, 32'h12345678);

        // Underflow below base wraps the word index
        run(1, 0, 32'd1020, 32'hCAFE0001, 0);
        chk("uf_addr_lo", addr_s[1], 32'h3FFFE);
        chk("uf_addr_hi", addr_s[3], 32'h3FFFF);
        chk("uf_mem", mem[18'h3FFFF], 32'hCAFE);

        // Reset during HI of a read
        @(negedge clk);
        mem_r_en = 1'b1;
        address  = 32'd1024;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("mid_in_hi", sram_oe_n, 0);
        chk("mid_pre_res", result, 32'h1234BEEF);
        rst = 1'b1;
        #1;
        chk("mid_result", result, 0);
        chk("mid_oe", sram_oe_n, 1);
        chk("mid_we", sram_we_n, 1);
        chk("mid_dqoe", sram_dq_oe, 0);
        chk("mid_addr", sram_addr, 0);
        mem_r_en = 1'b0;
        #1;
        chk("mid_ready", ready, 1);
        @(negedge clk);
        rst = 1'b0;
        run(0, 1, 32'd1024, 32'h0, 0);
        chk("post_low", nlow, 5);
        chk("post_result", res_done, 32'hDEADBEEF);

        // Longer wait setting on the second instance
        @(negedge clk);
        r3    = 1'b1;
        n3    = 0;
        seen3 = 1'b0;
        for (int i = 0; i < 30 && !seen3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            if (ready3) seen3 = 1'b1;
            else n3++;
        end
        r3 = 1'b0;
        chk("w3_done", seen3, 1);
        chk("w3_low", n3, 7);
        @(negedge clk);
        #1;
        chk("w3_idle_ready", ready3, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
